// File: rtl/ps2_kbd_decode_pkg.sv
// Shared constants and types for the PS/2 scancode-set-2 keyboard decoder.
// Defines the prefix bytes, the decoder state encoding and the buffered key-event layout.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_OVR0   = 8'h00;
  localparam logic [7:0] PS2_OVR1   = 8'hFF;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_SKIP
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

  function automatic logic is_overrun(input logic [7:0] b);
    return (b == PS2_OVR0) || (b == PS2_OVR1);
  endfunction

endpackage

// File: rtl/ps2_kbd_decode_if.sv
// Key-event valid/ready channel between the decoder FIFO head and the host keyboard registers.
// The master presents the event; the slave accepts it with ev_ready.
interface ps2_kbd_decode_if;

  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_ext,
    output ev_break,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_ext,
    input  ev_break,
    output ev_ready
  );

endinterface

// File: rtl/ps2_kbd_decode_fifo.sv
// Synchronous show-ahead FIFO: the head entry is driven combinationally from registered storage.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage carries no reset; empty_o masks stale contents at the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_decode.sv
// PS/2 keyboard byte decoder: checks odd parity, folds E0/F0/E1 prefixes into single key
// events and buffers them in a show-ahead FIFO toward the host.
module ps2_kbd_decode
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            code,
  input  logic                  parity,
  input  logic                  rdy,
  input  logic                  error,
  ps2_kbd_decode_if.master      ev,
  output logic                  perr,
  output logic                  kovr,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic [7:0]            err_cnt
);

  dec_state_e state_q;
  logic [2:0] skip_q;
  logic       perr_q;
  logic       kovr_q;
  logic       ovf_q;
  logic       error_q;
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  logic       good_byte;
  logic       bad_byte;
  logic       err_rise;
  logic       push;
  kbd_event_t push_ev;
  kbd_event_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       drop;

  assign good_byte = rdy && !error && (^{code, parity});
  assign bad_byte  = rdy && !error && !(^{code, parity});
  assign err_rise  = error && !error_q;
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  assign pop  = ev.ev_ready && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  // Event generation is combinational so the final byte of a sequence is written on its own edge.
  always_comb begin
    push    = 1'b0;
    push_ev = '0;
    if (good_byte) begin
      case (state_q)
        S_IDLE: begin
          if (code != PS2_EXT && code != PS2_BRK && code != PS2_PAUSE && !is_overrun(code)) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b0, brk: 1'b0, code: code};
          end
        end
        S_E0: begin
          if (code != PS2_BRK && code != PS2_EXT) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b1, brk: 1'b0, code: code};
          end
        end
        S_F0: begin
          push    = 1'b1;
          push_ev = '{ext: 1'b0, brk: 1'b1, code: code};
        end
        S_E0F0: begin
          push    = 1'b1;
          push_ev = '{ext: 1'b1, brk: 1'b1, code: code};
        end
        S_SKIP: begin
          if (skip_q == 3'd1) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b0, brk: 1'b0, code: PS2_PAUSE};
          end
        end
        default: begin
          push = 1'b0;
        end
      endcase
    end
  end

  // Decoder state, status pulses, error counter and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      skip_q    <= '0;
      perr_q    <= 1'b0;
      kovr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      error_q <= error;
      perr_q  <= bad_byte;
      kovr_q  <= good_byte && (state_q == S_IDLE) && is_overrun(code);

      if (err_rise || bad_byte) begin
        err_cnt_q <= err_cnt_d;
      end

      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end

      if (err_rise || bad_byte) begin
        state_q <= S_IDLE;
        skip_q  <= '0;
      end else if (good_byte) begin
        case (state_q)
          S_IDLE: begin
            if (code == PS2_EXT) begin
              state_q <= S_E0;
            end else if (code == PS2_BRK) begin
              state_q <= S_F0;
            end else if (code == PS2_PAUSE) begin
              state_q <= S_SKIP;
              skip_q  <= PAUSE_SKIP;
            end
          end
          S_E0: begin
            if (code == PS2_BRK) begin
              state_q <= S_E0F0;
            end else if (code != PS2_EXT) begin
              state_q <= S_IDLE;
            end
          end
          S_F0, S_E0F0: begin
            state_q <= S_IDLE;
          end
          S_SKIP: begin
            if (skip_q == 3'd1) begin
              state_q <= S_IDLE;
              skip_q  <= '0;
            end else begin
              skip_q <= skip_q - 3'd1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            skip_q  <= '0;
          end
        endcase
      end
    end
  end

  kbd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (10)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .data_i  (push_ev),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ev.ev_valid = !fifo_empty;
  assign ev.ev_code  = head.code;
  assign ev.ev_ext   = head.ext;
  assign ev.ev_break = head.brk;

  assign perr    = perr_q;
  assign kovr    = kovr_q;
  assign ovf     = ovf_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_decode.sv
// Scoreboard bench for ps2_kbd_decode: directed byte sequences push expected events into a
// queue, and a negedge monitor pops and compares each event the DUT hands over.
module tb_ps2_kbd_decode;
  import ps2_kbd_pkg::*;

  logic       clk;
  logic       resetN;
  logic [7:0] code;
  logic       parity;
  logic       rdy;
  logic       error;
  logic       perr;
  logic       kovr;
  logic       ovf;
  logic       ovfClr;
  logic [7:0] errCnt;

  int checkCount = 0;
  int passCount  = 0;
  int perrSeen   = 0;
  int kovrSeen   = 0;

  logic [9:0] expQ [$];

  ps2_kbd_decode_if evIf ();

  ps2_kbd_decode #(
    .DEPTH (8),
    .AW    (3)
  ) dut (
    .clk     (clk),
    .reset_n (resetN),
    .code    (code),
    .parity  (parity),
    .rdy     (rdy),
    .error   (error),
    .ev      (evIf),
    .perr    (perr),
    .kovr    (kovr),
    .ovf     (ovf),
    .ovf_clr (ovfClr),
    .err_cnt (errCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Present one byte for a single rdy cycle; bad selects a deliberately wrong parity bit.
  task automatic applyStimulus(input logic [7:0] c, input bit bad);
    @(posedge clk);
    #1;
    code   = c;
    parity = bad ? (^c) : ~(^c);
    rdy    = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
  endtask

  task automatic expectEvent(input bit ext, input bit brk, input logic [7:0] c);
    expQ.push_back({ext, brk, c});
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    checkOutput(name, expQ.size(), 0);
  endtask

  // Monitor: every accepted head event must match the oldest expected entry.
  always @(negedge clk) begin
    if (resetN) begin
      if (perr) perrSeen++;
      if (kovr) kovrSeen++;
      if (evIf.ev_valid && evIf.ev_ready) begin
        checkCount++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL unexpected_event: got 0x%0h, expected none",
                   {evIf.ev_ext, evIf.ev_break, evIf.ev_code});
        end else begin
          logic [9:0] exp;
          exp = expQ.pop_front();
          if ({evIf.ev_ext, evIf.ev_break, evIf.ev_code} !== exp) begin
            $display("[TB] FAIL event: got 0x%0h, expected 0x%0h",
                     {evIf.ev_ext, evIf.ev_break, evIf.ev_code}, exp);
          end else begin
            passCount++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN         = 1'b0;
    code           = 8'h00;
    parity         = 1'b0;
    rdy            = 1'b0;
    error          = 1'b0;
    ovfClr         = 1'b0;
    evIf.ev_ready  = 1'b0;

    #12;
    checkOutput("rst_ev_valid", evIf.ev_valid, 0);
    checkOutput("rst_ev_code", evIf.ev_code, 0);
    checkOutput("rst_ev_ext", evIf.ev_ext, 0);
    checkOutput("rst_ev_break", evIf.ev_break, 0);
    checkOutput("rst_perr", perr, 0);
    checkOutput("rst_kovr", kovr, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_err_cnt", errCnt, 0);
    resetN = 1'b1;

    // Make code then break code, held until ready so the head can be inspected.
    expectEvent(0, 0, 8'h1C);
    applyStimulus(8'h1C, 0);
    checkOutput("latency_valid", evIf.ev_valid, 1);
    checkOutput("head_code", evIf.ev_code, 32'h1C);
    expectEvent(0, 1, 8'h1C);
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h1C, 0);
    evIf.ev_ready = 1'b1;
    waitDrain("drain_make_break");

    // Extended break: prefixes alone must not produce anything.
    applyStimulus(8'hE0, 0);
    applyStimulus(8'hF0, 0);
    checkOutput("prefix_no_valid", evIf.ev_valid, 0);
    expectEvent(1, 1, 8'h75);
    applyStimulus(8'h75, 0);
    waitDrain("drain_ext_break");

    // Parity errors discard the byte and abandon a pending prefix.
    applyStimulus(8'h1C, 1);
    #10;
    checkOutput("perr_count_1", perrSeen, 1);
    checkOutput("err_cnt_1", errCnt, 1);
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h55, 1);
    expectEvent(0, 0, 8'h32);
    applyStimulus(8'h32, 0);
    waitDrain("drain_after_perr");
    checkOutput("perr_count_2", perrSeen, 2);
    checkOutput("err_cnt_2", errCnt, 2);

    // Pause sequence collapses to one event; a bare 00 is an overrun.
    expectEvent(0, 0, 8'hE1);
    applyStimulus(8'hE1, 0);
    applyStimulus(8'h14, 0);
    applyStimulus(8'h77, 0);
    applyStimulus(8'hE1, 0);
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h14, 0);
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h77, 0);
    waitDrain("drain_pause");
    applyStimulus(8'h00, 0);
    #10;
    checkOutput("kovr_count", kovrSeen, 1);
    checkOutput("kovr_no_valid", evIf.ev_valid, 0);

    // Framing error drops the E0 prefix and bumps the error counter.
    applyStimulus(8'hE0, 0);
    error = 1'b1;
    #20;
    error = 1'b0;
    checkOutput("err_cnt_frame", errCnt, 3);
    expectEvent(0, 0, 8'h75);
    applyStimulus(8'h75, 0);
    waitDrain("drain_after_frame");

    // Fill the FIFO, overflow by one, then drain in order.
    evIf.ev_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      expectEvent(0, 0, 8'(i));
      applyStimulus(8'(i), 0);
    end
    checkOutput("full_no_ovf", ovf, 0);
    applyStimulus(8'h09, 0);
    checkOutput("ovf_set", ovf, 1);
    checkOutput("full_head", evIf.ev_code, 32'h01);
    evIf.ev_ready = 1'b1;
    waitDrain("drain_full");
    checkOutput("ovf_sticky", ovf, 1);
    checkOutput("empty_after_drain", evIf.ev_valid, 0);
    ovfClr = 1'b1;
    @(posedge clk);
    #1;
    ovfClr = 1'b0;
    checkOutput("ovf_cleared", ovf, 0);

    // Asynchronous reset clears a pending perr pulse.
    applyStimulus(8'h1C, 1);
    checkOutput("perr_pending", perr, 1);
    resetN = 1'b0;
    #1;
    checkOutput("perr_reset", perr, 0);
    #1;
    resetN = 1'b1;

    // Asynchronous reset mid-prefix: the E0 is forgotten.
    applyStimulus(8'hE0, 0);
    resetN = 1'b0;
    #1;
    checkOutput("midseq_valid", evIf.ev_valid, 0);
    checkOutput("midseq_err_cnt", errCnt, 0);
    #1;
    resetN = 1'b1;
    expectEvent(0, 0, 8'h75);
    applyStimulus(8'h75, 0);
    waitDrain("drain_after_reset");

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
